// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one 4-bit add/subtract Adder, with a registered, tagged result.
// Define ADDER_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (req0 wins).

module Adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    output logic [3:0] sum,
    output logic       co
);
    logic [4:0] total;

    // Two's-complement subtract: invert b and inject the carry-in.
    always_comb begin
        total = {1'b0, a} + {1'b0, b ^ {4{sub}}} + {4'b0000, sub};
    end

    assign sum = total[3:0];
    assign co  = total[4];
endmodule

module adder_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic       sub0,
    input  logic       sub1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       res_valid,
    output logic       res_id,
    output logic [3:0] res_sum,
    output logic       res_co,
    input  logic       res_ack,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_sub;
    logic       op_id;
    logic       last;
    logic       grant;
    logic       winner;
    logic [3:0] add_sum;
    logic       add_co;

    Adder u_adder (
        .a   (op_a),
        .b   (op_b),
        .sub (op_sub),
        .sum (add_sum),
        .co  (add_co)
    );

    // winner is only meaningful when grant is high; with no request it just follows last.
    always_comb begin
        grant  = (state == IDLE) && (req0 || req1);
        winner = last;
`ifdef ADDER_ARB_RR_EN
        if (req0 && req1)
            winner = ~last;
        else if (req0)
            winner = 1'b0;
        else if (req1)
            winner = 1'b1;
`else
        if (req0)
            winner = 1'b0;
        else if (req1)
            winner = 1'b1;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = EXEC;
            EXEC:    state_next = WAIT;
            WAIT:    if (res_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Operands are captured on the grant edge so the Adder never sees the live inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            op_a   <= 4'd0;
            op_b   <= 4'd0;
            op_sub <= 1'b0;
            op_id  <= 1'b0;
            last   <= 1'b1;
        end else begin
            gnt0 <= grant && !winner;
            gnt1 <= grant && winner;
            if (grant) begin
                op_a   <= winner ? a1 : a0;
                op_b   <= winner ? b1 : b0;
                op_sub <= winner ? sub1 : sub0;
                op_id  <= winner;
                last   <= winner;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_sum   <= 4'd0;
            res_co    <= 1'b0;
        end else if (state == EXEC) begin
            res_valid <= 1'b1;
            res_id    <= op_id;
            res_sum   <= add_sum;
            res_co    <= add_co;
        end else if (state == WAIT && res_ack) begin
            res_valid <= 1'b0;
        end
    end

    assign busy = (state != IDLE);
endmodule
